// File: rtl/mult_pkg.sv
// Shared encodings for the sequential multiplier.
// WIDTH stays a module parameter; only the FSM encoding lives here.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Plain ripple-style adder with carry-in.
// Combinational, no backpressure; the sum wraps at W bits.
module seq_multiplier_adder #(
  parameter int W = 17
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b + {{(W-1){1'b0}}, i_cin};

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, signed or unsigned operands, sign-magnitude internally.
// Product in result WIDTH cycles after the start edge; start is ignored while busy.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_neg;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mplr_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_final;
  logic               w_last;

  // Negating -2^(WIDTH-1) yields itself, which read as unsigned is the correct magnitude.
  assign w_mag1 = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign w_mag2 = (is_signed && in2[WIDTH-1]) ? -in2 : in2;

  assign w_add_a = {1'b0, r_acc};
  assign w_add_b = r_mplr[0] ? {1'b0, r_mcand} : '0;

  seq_multiplier_adder #(
    .W (WIDTH + 1)
  ) u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  assign w_acc_nxt  = w_sum[WIDTH:1];
  assign w_mplr_nxt = {w_sum[0], r_mplr[WIDTH-1:1]};
  assign w_prod     = {w_acc_nxt, w_mplr_nxt};
  assign w_final    = r_neg ? -w_prod : w_prod;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_neg   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_mcand <= w_mag1;
            r_mplr  <= w_mag2;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            busy    <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc  <= w_acc_nxt;
          r_mplr <= w_mplr_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            result  <= w_final;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port is_signed, input, 1, selects two's-complement (1) or unsigned (0) operands; sampled with start.
REQ-006 SHALL have port in1, input, WIDTH, multiplicand; sampled with start.
REQ-007 SHALL have port in2, input, WIDTH, multiplier; sampled with start.
REQ-008 SHALL have port result, output, 2*WIDTH, registered product.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result valid.
REQ-010 SHALL have port busy, output, 1, high while the block is not in IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-012 In IDLE with start=1 at edge k, the block SHALL capture in1, in2 and is_signed, clear the accumulator and iteration counter, and enter CALC.
REQ-013 In signed mode, the block SHALL convert operands to magnitudes and SHALL record the product sign as in1[MSB] xor in2[MSB]. The value -2^(WIDTH-1) has magnitude 2^(WIDTH-1) and SHALL be handled without overflow.
REQ-014 CALC SHALL perform one radix-2 shift-add iteration per cycle, for exactly WIDTH cycles (edges k+1..k+WIDTH), using a WIDTH+1-bit add.
REQ-015 At edge k+WIDTH, result SHALL load the final product and the FSM SHALL enter DONE. The product SHALL be two's-complement negated if the recorded sign is 1.
REQ-016 done SHALL be high only while in DONE: exactly one cycle, WIDTH cycles after the start edge.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 result SHALL hold its value from entry to DONE until the next product is loaded; it SHALL NOT show intermediate accumulator values.
REQ-019 start SHALL be ignored while busy=1, including in DONE. Operand and mode changes during CALC SHALL have no effect.
REQ-020 start held high continuously SHALL begin a new multiply on every IDLE cycle, giving a throughput of one result per WIDTH+2 cycles.
REQ-021 The unsigned product SHALL be exact over the full 2*WIDTH range. The signed product SHALL be exact over the range representable in 2*WIDTH bits.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, counter 0, accumulator 0, result 0, done 0 and busy 0, regardless of the clock.
REQ-023 Reset asserted mid-CALC SHALL abandon the operation; no done pulse SHALL follow, and the first start after release SHALL be processed normally.
REQ-024 Deassertion of rst_n SHALL be assumed synchronous to clk by the integrator; no internal synchroniser is required.

Structure
REQ-025 State encodings (IDLE/CALC/DONE) SHALL reside in the shared package mult_pkg; WIDTH SHALL remain a module parameter.
REQ-026 The per-iteration addition SHALL instantiate the existing adder sub-module, parametrised to WIDTH+1 bits, with cin tied low.
REQ-027 The counter width SHALL be $clog2(WIDTH+1) bits; no other sub-modules are required.

Verification
REQ-028 WIDTH=16, unsigned, in1=16'h30CB, in2=16'h6F5E, start pulsed one cycle -> result=32'h1539EF8A, done high exactly 16 cycles after the start edge, busy low again the cycle after.
REQ-029 WIDTH=16 -> unsigned 16'hFFFF*16'hFFFF gives 32'hFFFE0001; signed 16'hFFFF*16'hFFFF gives 32'h00000001; signed 16'h8000*16'h8000 gives 32'h40000000; signed 16'h8000*16'h0001 gives 32'hFFFF8000.
REQ-030 Start re-pulsed during CALC with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-031 rst_n driven low at CALC iteration 7 and released, then start with 16'h0000*16'h1234 -> no done before the new start; result=0 after 16 cycles.
REQ-032 WIDTH=8 instance: unsigned 8'hFF*8'hFF gives 16'hFE01; signed 8'h80*8'h7F gives 16'hC080. With start held high, done pulses every 10 cycles.
REQ-033 Random regression of at least 10k operand/mode pairs at WIDTH=16 -> every result matches the reference model; done latency is always WIDTH.
